// File: rtl/data_bus_fabric.sv
// Data-side interconnect: decodes CPU loads/stores onto NUM_SLAVES req/ack slaves and stalls the CPU until done.
// Optional build macro BUS_TIMEOUT_EN adds a wait-cycle timeout and a sticky bus_err flag.
module data_bus_fabric #(
    parameter int unsigned NUM_SLAVES     = 4,
    parameter int unsigned REGION_LSB     = 12,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [31:0]                addr,
    input  logic [31:0]                write_data,
    input  logic                       memwrite,
    input  logic                       memread,
    input  logic [3:0]                 sign_mask,
    output logic [31:0]                read_data,
    output logic                       clk_stall,
    output logic [NUM_SLAVES-1:0]      slv_req,
    output logic [31:0]                slv_addr,
    output logic [31:0]                slv_wdata,
    output logic                       slv_we,
    output logic                       slv_re,
    output logic [3:0]                 slv_sign_mask,
    input  logic [32*NUM_SLAVES-1:0]   slv_rdata,
    input  logic [NUM_SLAVES-1:0]      slv_ack,
    output logic                       bus_err
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned IDX_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int unsigned IDX_EW = IDX_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;

    logic [IDX_W-1:0]      w_idx;
    logic [IDX_W-1:0]      r_idx;
    logic [IDX_W-1:0]      w_sel_idx;
    logic                  w_mapped;
    logic                  w_req;
    logic                  w_ack;
    logic                  w_timeout;
    logic                  w_clk_stall;
    logic [NUM_SLAVES-1:0] w_onehot;
    logic [DATA_W-1:0]     w_rdata_sel;

    logic [NUM_SLAVES-1:0] r_slv_req;
    logic [31:0]           r_addr;
    logic [31:0]           r_wdata;
    logic                  r_we;
    logic                  r_re;
    logic [3:0]            r_sign_mask;
    logic [DATA_W-1:0]     r_read_data;

    // Address decode of the live CPU request
    assign w_idx     = addr[REGION_LSB +: IDX_W];
    assign w_mapped  = ({1'b0, w_idx} < IDX_EW'(NUM_SLAVES));
    assign w_req     = memread | memwrite;
    assign w_sel_idx = (r_state == ST_IDLE) ? w_idx : r_idx;

    // One-hot request and ack/rdata selection for the addressed slave
    always_comb begin
        w_onehot    = '0;
        w_ack       = 1'b0;
        w_rdata_sel = '0;
        for (int k = 0; k < int'(NUM_SLAVES); k++) begin
            if (w_sel_idx == IDX_W'(k)) begin
                w_onehot[k] = 1'b1;
                w_ack       = slv_ack[k];
                w_rdata_sel = slv_rdata[DATA_W*k +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and the combinational CPU stall
    always_comb begin
        w_next_state = r_state;
        w_clk_stall  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_clk_stall = rst_n & w_req;
                if (w_req) begin
                    w_next_state = w_mapped ? ST_ACCESS : ST_DONE;
                end
            end
            ST_ACCESS: begin
                w_clk_stall = 1'b1;
                if (w_ack || w_timeout) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Latched access attributes, slave request and load result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_slv_req   <= '0;
            r_idx       <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_we        <= 1'b0;
            r_re        <= 1'b0;
            r_sign_mask <= '0;
            r_read_data <= '0;
        end else begin
            r_slv_req <= (w_next_state == ST_ACCESS) ? w_onehot : '0;
            if (r_state == ST_IDLE && w_req) begin
                r_idx       <= w_idx;
                r_addr      <= addr;
                r_wdata     <= write_data;
                r_we        <= memwrite;
                r_re        <= memread & ~memwrite;
                r_sign_mask <= sign_mask;
                if (!w_mapped && !memwrite) begin
                    r_read_data <= '0;
                end
            end
            if (r_state == ST_ACCESS && r_re) begin
                if (w_ack) begin
                    r_read_data <= w_rdata_sel;
                end else if (w_timeout) begin
                    r_read_data <= '0;
                end
            end
        end
    end

`ifdef BUS_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_bus_err;

    // Saturating count of ACCESS cycles; zero outside ACCESS
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
        end else if (r_state == ST_ACCESS) begin
            if (r_wait_cnt != {CNT_W{1'b1}}) begin
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            end
        end else begin
            r_wait_cnt <= '0;
        end
    end

    // Last permitted ACCESS cycle is the one where the count equals TIMEOUT_CYCLES-1
    assign w_timeout = (r_state == ST_ACCESS) && (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bus_err <= 1'b0;
        end else if ((r_state == ST_IDLE && w_req && !w_mapped) ||
                     (r_state == ST_ACCESS && !w_ack && w_timeout)) begin
            r_bus_err <= 1'b1;
        end
    end

    assign bus_err = r_bus_err;
`else
    logic w_unused_timeout;

    assign w_unused_timeout = ^32'(TIMEOUT_CYCLES);
    assign w_timeout        = 1'b0;
    assign bus_err          = 1'b0;
`endif

    assign clk_stall     = w_clk_stall;
    assign slv_req       = r_slv_req;
    assign slv_addr      = r_addr;
    assign slv_wdata     = r_wdata;
    assign slv_we        = r_we;
    assign slv_re        = r_re;
    assign slv_sign_mask = r_sign_mask;
    assign read_data     = r_read_data;

endmodule

// File: tb/tb_data_bus_fabric.sv
// Scoreboard bench for data_bus_fabric: a 4-slave instance with programmable-latency slaves
// and a 3-slave instance whose index 3 is unmapped.
module tb_data_bus_fabric;

    localparam int unsigned TO = 8;

    typedef struct {
        logic [31:0] rd;
        int          stalls;
        logic [3:0]  req;
        logic        err;
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  sm;
    } exp_t;

    logic clk;
    logic rst_n;

    // 4-slave instance
    logic [31:0]  a_addr, a_wdata, a_rd, a_saddr, a_swdata;
    logic         a_we, a_re, a_stall, a_swe, a_sre, a_err;
    logic [3:0]   a_sm, a_ssm, a_req, a_ack, force_ack;
    logic [127:0] a_rdata;

    // 3-slave instance
    logic [31:0]  b_addr, b_wdata, b_rdv, b_saddr, b_swdata;
    logic         b_we, b_re, b_stall, b_swe, b_sre, b_err;
    logic [3:0]   b_sm, b_ssm;
    logic [2:0]   b_req, b_ack;
    logic [95:0]  b_rdata;

    int unsigned  s_dly [4];
    logic [31:0]  s_rd  [4];
    int unsigned  s_cnt [4];
    logic [31:0]  b_rd  [4];

    logic [31:0]  exp_rd_a, exp_rd_b;
    logic         exp_err_a, exp_err_b;
    exp_t         sb_q[$];
    int           n_checks;
    int           n_fail;

    data_bus_fabric #(.NUM_SLAVES(4), .REGION_LSB(12), .TIMEOUT_CYCLES(TO)) u_dut (
        .clk(clk), .rst_n(rst_n), .addr(a_addr), .write_data(a_wdata),
        .memwrite(a_we), .memread(a_re), .sign_mask(a_sm), .read_data(a_rd),
        .clk_stall(a_stall), .slv_req(a_req), .slv_addr(a_saddr), .slv_wdata(a_swdata),
        .slv_we(a_swe), .slv_re(a_sre), .slv_sign_mask(a_ssm), .slv_rdata(a_rdata),
        .slv_ack(a_ack), .bus_err(a_err)
    );

    data_bus_fabric #(.NUM_SLAVES(3), .REGION_LSB(12), .TIMEOUT_CYCLES(TO)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .addr(b_addr), .write_data(b_wdata),
        .memwrite(b_we), .memread(b_re), .sign_mask(b_sm), .read_data(b_rdv),
        .clk_stall(b_stall), .slv_req(b_req), .slv_addr(b_saddr), .slv_wdata(b_swdata),
        .slv_we(b_swe), .slv_re(b_sre), .slv_sign_mask(b_ssm), .slv_rdata(b_rdata),
        .slv_ack(b_ack), .bus_err(b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave k acks on the s_dly[k]-th cycle of its request; 0 means never
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            s_cnt[k] <= a_req[k] ? s_cnt[k] + 1 : 0;
        end
    end

    always_comb begin
        a_ack = force_ack;
        for (int k = 0; k < 4; k++) begin
            if (a_req[k] && s_dly[k] != 0 && s_cnt[k] + 1 == s_dly[k]) begin
                a_ack[k] = 1'b1;
            end
        end
    end

    assign a_rdata = {s_rd[3], s_rd[2], s_rd[1], s_rd[0]};
    assign b_rdata = {b_rd[2], b_rd[1], b_rd[0]};
    assign b_ack   = 3'b111;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic obs_stall(input bit on_b);
        return on_b ? b_stall : a_stall;
    endfunction

    function automatic logic [3:0] obs_req(input bit on_b);
        return on_b ? {1'b0, b_req} : a_req;
    endfunction

    task automatic idle(input int n);
        @(negedge clk);
        a_re = 1'b0; a_we = 1'b0; b_re = 1'b0; b_we = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Predict one access, drive it, then measure stall length and compare at DONE
    task automatic run_access(input bit on_b, input logic [31:0] a, input logic [31:0] wd,
                              input logic we, input logic re, input logic [3:0] sm);
        exp_t        e;
        exp_t        got;
        int unsigned idx;
        int unsigned d;
        bit          is_rd;
        int          stalls;
        logic [3:0]  req_or;
        bit          done;
        idx    = int'(a[13:12]);
        is_rd  = re && !we;
        e.we   = we;
        e.re   = is_rd;
        e.addr = a;
        e.wd   = wd;
        e.sm   = sm;
        e.rd   = on_b ? exp_rd_b : exp_rd_a;
        e.err  = on_b ? exp_err_b : exp_err_a;
        if (idx >= (on_b ? 3 : 4)) begin
            e.stalls = 1;
            e.req    = '0;
            if (is_rd) e.rd = '0;
`ifdef BUS_TIMEOUT_EN
            e.err = 1'b1;
`endif
        end else begin
            d        = on_b ? 1 : s_dly[idx];
            e.req    = 4'(1 << idx);
            e.stalls = 1 + int'(d);
            if (is_rd) e.rd = on_b ? b_rd[idx] : s_rd[idx];
`ifdef BUS_TIMEOUT_EN
            if (d == 0 || d > TO) begin
                e.stalls = 1 + int'(TO);
                if (is_rd) e.rd = '0;
                e.err = 1'b1;
            end
`endif
        end
        if (on_b) begin exp_rd_b = e.rd; exp_err_b = e.err; end
        else      begin exp_rd_a = e.rd; exp_err_a = e.err; end
        sb_q.push_back(e);

        @(negedge clk);
        if (on_b) begin b_addr = a; b_wdata = wd; b_we = we; b_re = re; b_sm = sm; end
        else      begin a_addr = a; a_wdata = wd; a_we = we; a_re = re; a_sm = sm; end
        #1;
        check("idle_req_clear", 32'(obs_req(on_b)), 32'h0);
        stalls = 0;
        req_or = '0;
        done   = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            if (obs_stall(on_b)) begin
                stalls++;
                req_or |= obs_req(on_b);
                @(negedge clk);
                #1;
            end else begin
                done = 1'b1;
            end
        end
        if (!done) check("done_bound", 32'h0, 32'h1);

        got = sb_q.pop_front();
        check("stall_cycles", 32'(stalls), 32'(got.stalls));
        check("req_onehot",   32'(req_or), 32'(got.req));
        check("done_req",     32'(obs_req(on_b)), 32'h0);
        check("read_data",    on_b ? b_rdv : a_rd, got.rd);
        check("bus_err",      32'(on_b ? b_err : a_err), 32'(got.err));
        check("slv_we",       32'(on_b ? b_swe : a_swe), 32'(got.we));
        check("slv_re",       32'(on_b ? b_sre : a_sre), 32'(got.re));
        check("slv_addr",     on_b ? b_saddr : a_saddr, got.addr);
        check("slv_wdata",    on_b ? b_swdata : a_swdata, got.wd);
        check("slv_sign_mask", 32'(on_b ? b_ssm : a_ssm), 32'(got.sm));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        force_ack = '0;
        a_addr = 32'h1004; a_wdata = '0; a_we = 1'b0; a_re = 1'b1; a_sm = '0;
        b_addr = 32'h0000; b_wdata = '0; b_we = 1'b0; b_re = 1'b1; b_sm = '0;
        for (int k = 0; k < 4; k++) begin
            s_dly[k] = 1;
            s_rd[k]  = 32'h0;
        end
        b_rd[0] = 32'h1111_1111; b_rd[1] = 32'h2222_2222;
        b_rd[2] = 32'h3333_3333; b_rd[3] = 32'h0;
        exp_rd_a = '0; exp_rd_b = '0; exp_err_a = 1'b0; exp_err_b = 1'b0;

        // Reset holds everything at zero and masks the stall despite pending requests
        repeat (2) @(negedge clk);
        #1;
        check("rst_stall_a", 32'(a_stall), 32'h0);
        check("rst_stall_b", 32'(b_stall), 32'h0);
        check("rst_req",     32'(a_req), 32'h0);
        check("rst_rdata",   a_rd, 32'h0);
        check("rst_err",     32'(a_err), 32'h0);
        check("rst_saddr",   a_saddr, 32'h0);
        check("rst_we_re",   32'({a_swe, a_sre}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1; a_re = 1'b0; b_re = 1'b0;

        s_dly[1] = 1; s_rd[1] = 32'hCAFE_F00D;
        run_access(1'b0, 32'h0000_1004, 32'h0, 1'b0, 1'b1, 4'b1111);
        idle(1);
        s_dly[2] = 5;
        run_access(1'b0, 32'h0000_2000, 32'h1234_5678, 1'b1, 1'b0, 4'b0011);
        idle(1);
        s_dly[3] = 3; s_rd[3] = 32'h7777_0003;
        run_access(1'b0, 32'h0000_7000, 32'h0, 1'b0, 1'b1, 4'b0001);
        idle(1);
        s_dly[0] = 2; s_rd[0] = 32'hDEAD_0000;
        run_access(1'b0, 32'h0000_0010, 32'h5555_AAAA, 1'b1, 1'b1, 4'b1111);
        idle(1);

        // Acks from non-selected slaves must not end the access early
        force_ack = 4'b1011;
        s_dly[2] = 3; s_rd[2] = 32'hA5A5_0002;
        run_access(1'b0, 32'h0000_2008, 32'h0, 1'b0, 1'b1, 4'b0111);
        idle(1);
        force_ack = '0;
        idle(1);

        // Back-to-back loads to slave 0 then slave 3
        s_dly[0] = 1; s_rd[0] = 32'h0000_0A0A;
        s_dly[3] = 2; s_rd[3] = 32'h3C3C_3C3C;
        run_access(1'b0, 32'h0000_0000, 32'h0, 1'b0, 1'b1, 4'b1111);
        run_access(1'b0, 32'h0000_3004, 32'h0, 1'b0, 1'b1, 4'b1111);
        idle(1);

        // Three-slave instance: index 3 is unmapped
        run_access(1'b1, 32'h0000_2000, 32'h0, 1'b0, 1'b1, 4'b1111);
        idle(1);
        run_access(1'b1, 32'h0000_3000, 32'h0, 1'b0, 1'b1, 4'b1111);
        run_access(1'b1, 32'h0000_7000, 32'hBEEF_0001, 1'b1, 1'b0, 4'b0011);
        idle(1);

`ifdef BUS_TIMEOUT_EN
        // Silent slave is abandoned after TO ACCESS cycles; bus_err stays until reset
        s_dly[1] = 0;
        run_access(1'b0, 32'h0000_1000, 32'h0, 1'b0, 1'b1, 4'b1111);
        idle(1);
        s_dly[1] = 1; s_rd[1] = 32'h0BAD_CAFE;
        run_access(1'b0, 32'h0000_1008, 32'h0, 1'b0, 1'b1, 4'b1111);
        idle(1);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check("err_cleared", 32'(a_err), 32'h0);
        rst_n = 1'b1;
        exp_rd_a = '0; exp_rd_b = '0; exp_err_a = 1'b0; exp_err_b = 1'b0;
        s_rd[1] = 32'h1357_9BDF;
        run_access(1'b0, 32'h0000_1000, 32'h0, 1'b0, 1'b1, 4'b1111);
        idle(1);
`endif

        // Reset in the middle of ACCESS aborts it; a late ack is ignored
        s_dly[2] = 0;
        @(negedge clk);
        a_addr = 32'h0000_2000; a_re = 1'b1; a_we = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("mid_access_req",   32'(a_req), 32'h4);
        check("mid_access_stall", 32'(a_stall), 32'h1);
        @(negedge clk);
        rst_n = 1'b0; a_re = 1'b0;
        @(negedge clk);
        #1;
        check("abort_req",   32'(a_req), 32'h0);
        check("abort_stall", 32'(a_stall), 32'h0);
        check("abort_rdata", a_rd, 32'h0);
        check("abort_rdata_b", b_rdv, 32'h0);
        rst_n = 1'b1;
        force_ack = 4'b0100;
        @(negedge clk);
        #1;
        force_ack = '0;
        check("late_ack_stall", 32'(a_stall), 32'h0);
        check("late_ack_req",   32'(a_req), 32'h0);
        check("late_ack_rdata", a_rd, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
